// File: rtl/cnn_pkg.sv
// Shared constants for the LeNet front end: sample/bus sizes, layer-1 frame
// dimensions and the pooling stage's state encoding.
package cnn_pkg;

   localparam int DATA_WIDTH      = 16;
   localparam int CH_NUM          = 6;
   localparam int L1_IMG_W        = 28;
   localparam int L1_IMG_H        = 28;
   localparam int L1_POOL_W       = 14;
   localparam int L1_POOL_H       = 14;
   localparam int POOL_ADDR_WIDTH = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } pool_state_t;

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer for 2x2 pooling: one synchronous write port and one
// asynchronous read port sharing a single index (col>>1).
module pool_line_buf #(
   parameter int DEPTH = cnn_pkg::L1_POOL_W,
   parameter int WIDTH = cnn_pkg::DATA_WIDTH * cnn_pkg::CH_NUM,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] idx,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data
);
   import cnn_pkg::*;

   // No reset: every entry is written on an even row before an odd row reads it.
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[idx] <= wr_data;
   end

   assign rd_data = mem[idx];

endmodule

// File: rtl/max_pool_1.sv
// 2x2 stride-2 max pooling on a raster 6-channel stream, computed on the fly
// with one hold register and a half-width line buffer.
module max_pool_1 #(
   parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
   parameter int CH_NUM     = cnn_pkg::CH_NUM,
   parameter int IMG_W      = cnn_pkg::L1_IMG_W,
   parameter int IMG_H      = cnn_pkg::L1_IMG_H,
   parameter int ADDR_WIDTH = cnn_pkg::POOL_ADDR_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         layer_enable,
   input  logic [DATA_WIDTH*CH_NUM-1:0] in_bus,
   input  logic                         in_wr_en,
   output logic [DATA_WIDTH*CH_NUM-1:0] out_bus,
   output logic                         out_wr_en,
   output logic [ADDR_WIDTH-1:0]        out_addr,
   output logic                         frame_done,
   output logic                         busy
);
   import cnn_pkg::*;

   localparam int BUS_W  = DATA_WIDTH * CH_NUM;
   localparam int COL_W  = $clog2(IMG_W);
   localparam int ROW_W  = $clog2(IMG_H);
   localparam int HALF_W = IMG_W / 2;
   localparam int IDX_W  = COL_W - 1;

   // Handshake: in_wr_en and out_wr_en are valid strobes with no ready; each
   // pulse carries one word that is consumed in that same cycle.
   pool_state_t      state, state_next;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [BUS_W-1:0] hold, lb_rd, max_a, max_y;
   logic [IDX_W-1:0] half_col;
   logic             accept, last_px, lb_wr;

   function automatic logic [BUS_W-1:0] chmax(input logic [BUS_W-1:0] a,
                                              input logic [BUS_W-1:0] b);
      logic [BUS_W-1:0] r;
      r = '0;
      for (int k = 0; k < CH_NUM; k++) begin
         if ($signed(a[k*DATA_WIDTH +: DATA_WIDTH]) > $signed(b[k*DATA_WIDTH +: DATA_WIDTH]))
            r[k*DATA_WIDTH +: DATA_WIDTH] = a[k*DATA_WIDTH +: DATA_WIDTH];
         else
            r[k*DATA_WIDTH +: DATA_WIDTH] = b[k*DATA_WIDTH +: DATA_WIDTH];
      end
      return r;
   endfunction

   // A pixel arriving with layer_enable is dropped: the restart wins.
   assign accept   = (state == ST_RUN) && in_wr_en && !layer_enable;
   assign last_px  = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));
   assign half_col = col[COL_W-1:1];
   assign lb_wr    = accept && !row[0] && col[0];
   assign busy     = (state == ST_RUN);

   // Only the odd-row/even-col step folds in the line buffer; all others use hold.
   assign max_a = (row[0] && !col[0]) ? lb_rd : hold;
   assign max_y = chmax(max_a, in_bus);

   pool_line_buf #(
      .DEPTH (HALF_W),
      .WIDTH (BUS_W),
      .IDX_W (IDX_W)
   ) u_line_buf (
      .clk     (clk),
      .wr_en   (lb_wr),
      .idx     (half_col),
      .wr_data (max_y),
      .rd_data (lb_rd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (layer_enable)
         state_next = ST_RUN;
      else if (accept && last_px)
         state_next = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col        <= '0;
         row        <= '0;
         hold       <= '0;
         out_bus    <= '0;
         out_wr_en  <= 1'b0;
         out_addr   <= '0;
         frame_done <= 1'b0;
      end else begin
         out_wr_en  <= 1'b0;
         frame_done <= 1'b0;
         if (layer_enable) begin
            col <= '0;
            row <= '0;
         end else if (accept) begin
            case ({row[0], col[0]})
               2'b00:   hold <= in_bus;
               2'b10:   hold <= max_y;
               2'b11: begin
                  out_bus    <= max_y;
                  out_wr_en  <= 1'b1;
                  out_addr   <= ADDR_WIDTH'((32'(row) >> 1) * HALF_W + 32'(half_col));
                  frame_done <= last_px;
               end
               default: ;
            endcase
            if (col == COL_W'(IMG_W - 1)) begin
               col <= '0;
               row <= last_px ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_max_pool_1.sv
// Scoreboard bench for max_pool_1: a frame model predicts each pooled word,
// address, frame_done flag and arrival cycle; a monitor pops and compares.
module tb_max_pool_1;

   localparam int DW    = 16;
   localparam int CH    = 6;
   localparam int W     = 28;
   localparam int H     = 28;
   localparam int AW    = 16;
   localparam int BUS_W = DW * CH;
   localparam int NPIX  = W * H;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             layer_enable = 1'b0;
   logic [BUS_W-1:0] in_bus = '0;
   logic             in_wr_en = 1'b0;
   logic [BUS_W-1:0] out_bus;
   logic             out_wr_en;
   logic [AW-1:0]    out_addr;
   logic             frame_done;
   logic             busy;

   max_pool_1 #(
      .DATA_WIDTH (DW),
      .CH_NUM     (CH),
      .IMG_W      (W),
      .IMG_H      (H),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .layer_enable (layer_enable),
      .in_bus       (in_bus),
      .in_wr_en     (in_wr_en),
      .out_bus      (out_bus),
      .out_wr_en    (out_wr_en),
      .out_addr     (out_addr),
      .frame_done   (frame_done),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   int cyc = 0;
   int out_count = 0;
   int fd_count = 0;

   logic [BUS_W-1:0] pix [H][W];
   logic [BUS_W-1:0] exp_q[$];
   logic [AW-1:0]    exp_addr_q[$];
   logic             exp_fd_q[$];
   int               exp_cyc_q[$];

   always @(posedge clk) cyc++;

   // Reference: per-channel signed max over the four pixels of the window.
   function automatic logic [BUS_W-1:0] win_max(input int r, input int c);
      logic [BUS_W-1:0] res;
      logic signed [DW-1:0] m, v;
      res = '0;
      for (int k = 0; k < CH; k++) begin
         m = pix[r-1][c-1][k*DW +: DW];
         v = pix[r-1][c][k*DW +: DW];   if (v > m) m = v;
         v = pix[r][c-1][k*DW +: DW];   if (v > m) m = v;
         v = pix[r][c][k*DW +: DW];     if (v > m) m = v;
         res[k*DW +: DW] = m;
      end
      return res;
   endfunction

   // Monitor: every out_wr_en pulse is matched against the head of the queue.
   always @(negedge clk) begin
      if (rst_n && out_wr_en) begin
         out_count++;
         if (frame_done) fd_count++;
         checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_output: got addr %0d data %h, none expected", out_addr, out_bus);
         end else begin
            logic [BUS_W-1:0] ed;
            logic [AW-1:0]    ea;
            logic             ef;
            int               ec;
            ed = exp_q.pop_front();
            ea = exp_addr_q.pop_front();
            ef = exp_fd_q.pop_front();
            ec = exp_cyc_q.pop_front();
            if (out_bus !== ed || out_addr !== ea || frame_done !== ef || cyc !== ec)
               $display("FAIL output: got data %h addr %0d fd %b cyc %0d, expected data %h addr %0d fd %b cyc %0d",
                        out_bus, out_addr, frame_done, cyc, ed, ea, ef, ec);
            else
               passed++;
         end
      end else if (rst_n && frame_done) begin
         checks++;
         $display("FAIL frame_done_alone: frame_done=1 with out_wr_en=0 at cyc %0d", cyc);
      end
   end

   task automatic fill_frame(input bit ramp);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            if (ramp) pix[r][c] = {CH{16'(r * W + c)}};
            else      pix[r][c] = {$urandom, $urandom, $urandom};
   endtask

   task automatic start_frame(input bit with_px);
      layer_enable = 1'b1;
      in_wr_en     = with_px;
      in_bus       = {$urandom, $urandom, $urandom};
      @(posedge clk); #1;
      layer_enable = 1'b0;
      in_wr_en     = 1'b0;
   endtask

   task automatic drive_pixel(input int r, input int c);
      in_bus   = pix[r][c];
      in_wr_en = 1'b1;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
         exp_q.push_back(win_max(r, c));
         exp_addr_q.push_back(AW'((r / 2) * (W / 2) + c / 2));
         exp_fd_q.push_back((r == H - 1) && (c == W - 1));
         exp_cyc_q.push_back(cyc + 1);
      end
      @(posedge clk); #1;
      in_wr_en = 1'b0;
   endtask

   task automatic drive_range(input int first, input int last, input bit gappy);
      for (int i = first; i <= last; i++) begin
         while (gappy && $urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
         end
         drive_pixel(i / W, i % W);
      end
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
         @(negedge clk); #1;
      end
      @(negedge clk); #1;
      checks++;
      if (exp_q.size() != 0) begin
         $display("FAIL %s_drain: %0d outputs still pending, required 0", name, exp_q.size());
         exp_q.delete(); exp_addr_q.delete(); exp_fd_q.delete(); exp_cyc_q.delete();
      end else begin
         passed++;
      end
   endtask

   task automatic test_reset();
      checks++; if (out_bus !== '0)     $display("FAIL reset_out_bus: got %h, required 0", out_bus);       else passed++;
      checks++; if (out_wr_en !== 1'b0) $display("FAIL reset_out_wr_en: got %b, required 0", out_wr_en);   else passed++;
      checks++; if (out_addr !== '0)    $display("FAIL reset_out_addr: got %0d, required 0", out_addr);    else passed++;
      checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b, required 0", frame_done); else passed++;
      checks++; if (busy !== 1'b0)      $display("FAIL reset_busy: got %b, required 0", busy);             else passed++;
   endtask

   task automatic test_ramp_frame(input string name, input bit gappy);
      int oc, fc;
      fill_frame(1'b1);
      oc = out_count; fc = fd_count;
      start_frame(1'b0);
      checks++; if (busy !== 1'b1) $display("FAIL %s_busy_run: got %b, required 1", name, busy); else passed++;
      drive_range(0, NPIX - 1, gappy);
      wait_drain(name);
      checks++; if (out_count - oc !== 196) $display("FAIL %s_count: got %0d, required 196", name, out_count - oc); else passed++;
      checks++; if (fd_count - fc !== 1)    $display("FAIL %s_fd_count: got %0d, required 1", name, fd_count - fc);  else passed++;
      checks++; if (busy !== 1'b0)          $display("FAIL %s_busy_end: got %b, required 0", name, busy);            else passed++;
      checks++; if (out_addr !== AW'(195))  $display("FAIL %s_addr_hold: got %0d, required 195", name, out_addr);    else passed++;
      checks++;
      if (out_bus[0 +: DW] !== 16'd783) $display("FAIL %s_data_hold: got %0d, required 783", name, out_bus[0 +: DW]);
      else passed++;
   endtask

   task automatic test_signed_max();
      logic [DW-1:0] c0v [4];
      logic [DW-1:0] c5v [4];
      c0v = '{16'hFFFB, 16'hFFFD, 16'hFFF8, 16'hFFFF};
      c5v = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0001};
      fill_frame(1'b0);
      for (int i = 0; i < 4; i++) begin
         pix[i / 2][i % 2][0 +: DW]      = c0v[i];
         pix[i / 2][i % 2][5 * DW +: DW] = c5v[i];
      end
      start_frame(1'b0);
      drive_range(0, W + 1, 1'b0);
      checks++; if (out_wr_en !== 1'b1) $display("FAIL signed_first_valid: got %b, required 1", out_wr_en); else passed++;
      checks++;
      if (out_bus[0 +: DW] !== 16'hFFFF) $display("FAIL signed_ch0: got %h, required ffff", out_bus[0 +: DW]);
      else passed++;
      checks++;
      if (out_bus[5 * DW +: DW] !== 16'h7FFF) $display("FAIL signed_ch5: got %h, required 7fff", out_bus[5 * DW +: DW]);
      else passed++;
      drive_range(W + 2, NPIX - 1, 1'b0);
      wait_drain("signed");
   endtask

   task automatic test_idle_guard();
      int oc;
      oc = out_count;
      for (int i = 0; i < 10; i++) begin
         in_bus   = {$urandom, $urandom, $urandom};
         in_wr_en = 1'b1;
         @(posedge clk); #1;
         in_wr_en = 1'b0;
         @(posedge clk); #1;
      end
      checks++; if (out_count !== oc) $display("FAIL idle_no_output: got %0d outputs, required 0", out_count - oc); else passed++;
      checks++; if (busy !== 1'b0)    $display("FAIL idle_busy: got %b, required 0", busy);                        else passed++;
      fill_frame(1'b0);
      start_frame(1'b1);
      drive_range(0, NPIX - 1, 1'b0);
      wait_drain("idle_frame");
   endtask

   task automatic test_restart();
      int oc, fc;
      oc = out_count; fc = fd_count;
      fill_frame(1'b0);
      start_frame(1'b0);
      drive_range(0, 299, 1'b0);
      fill_frame(1'b0);
      start_frame(1'b1);
      drive_range(0, NPIX - 1, 1'b0);
      wait_drain("restart");
      // 300 pixels close 5 rows of windows (70) before the full 196-window frame.
      checks++; if (out_count - oc !== 266) $display("FAIL restart_count: got %0d, required 266", out_count - oc); else passed++;
      checks++; if (fd_count - fc !== 1)    $display("FAIL restart_fd_count: got %0d, required 1", fd_count - fc);  else passed++;
   endtask

   task automatic test_reset_mid_frame();
      fill_frame(1'b0);
      start_frame(1'b0);
      drive_range(0, 99, 1'b0);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      test_reset();
      exp_q.delete(); exp_addr_q.delete(); exp_fd_q.delete(); exp_cyc_q.delete();
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_ramp_frame("ramp_after_reset", 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_ramp_frame("ramp", 1'b0);
      test_signed_max();
      test_ramp_frame("gappy", 1'b1);
      test_idle_guard();
      test_restart();
      test_reset_mid_frame();
      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
